// File: rtl/rc_pulse_capture_pkg.sv
// Shared UAV constants for RC pulse capture: prescaler default, throttle scaling and FSM states.
package rc_pulse_capture_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 50;
    localparam int unsigned WIDTH_BITS      = 12;
    localparam int unsigned THR_OFFSET_US   = 1000;
    localparam int unsigned THR_MAX_US      = 2000;
    localparam int unsigned THR_SCALE       = 262;
    localparam int unsigned THR_SHIFT       = 10;

    typedef enum logic [1:0] {
        ST_WAIT_LOW  = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2
    } cap_state_e;

    // Clamp to [1000,2000] us, then ((c-1000)*262)>>10 in a 19-bit product.
    function automatic logic [7:0] scale_throttle(input logic [WIDTH_BITS-1:0] width_us);
        logic [WIDTH_BITS-1:0] c;
        logic [18:0]           diff;
        logic [18:0]           prod;
        if (width_us < WIDTH_BITS'(THR_OFFSET_US)) begin
            c = WIDTH_BITS'(THR_OFFSET_US);
        end else if (width_us > WIDTH_BITS'(THR_MAX_US)) begin
            c = WIDTH_BITS'(THR_MAX_US);
        end else begin
            c = width_us;
        end
        diff = 19'(c) - 19'(THR_OFFSET_US);
        prod = diff * 19'(THR_SCALE);
        return 8'(prod >> THR_SHIFT);
    endfunction

endpackage

// File: rtl/tick_1us.sv
// Free-running prescaler: one-cycle enable every CLK_DIV clocks.
module tick_1us
    import rc_pulse_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clock_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q  <= CW'(CLK_DIV - 1);
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q - 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/rc_pulse_capture.sv
// RC receiver pulse-width capture with range check, throttle scaling and failsafe/recovery.
//   state        | meaning
//   ST_WAIT_LOW  | wait for a genuine low level before arming
//   ST_WAIT_RISE | armed, waiting for the rising edge
//   ST_MEASURE   | counting us ticks until the falling edge
module rc_pulse_capture
    import rc_pulse_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_DEFAULT,
    parameter int unsigned MIN_VALID_US = 800,
    parameter int unsigned MAX_VALID_US = 2200,
    parameter int unsigned TIMEOUT_US   = 25000,
    parameter int unsigned RECOVER_CNT  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rc_in,
    output logic [WIDTH_BITS-1:0] pulse_us,
    output logic [7:0]            throttle_setting,
    output logic                  valid,
    output logic                  failsafe
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_US + 1);
    localparam int unsigned RC_W = (RECOVER_CNT > 1) ? $clog2(RECOVER_CNT + 1) : 1;

    localparam logic [WIDTH_BITS-1:0] MIN_W    = WIDTH_BITS'(MIN_VALID_US);
    localparam logic [WIDTH_BITS-1:0] MAX_W    = WIDTH_BITS'(MAX_VALID_US);
    localparam logic [WIDTH_BITS-1:0] WIDTH_SAT = '1;
    localparam logic [TO_W-1:0]       TO_MAX   = TO_W'(TIMEOUT_US);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_US - 1);
    localparam logic [RC_W-1:0]       RC_LAST  = RC_W'(RECOVER_CNT - 1);

    logic                  tick;
    logic                  sync1_q, sync2_q, prev_q;
    logic [1:0]            sync_vld_q;
    cap_state_e            state_q;
    logic [WIDTH_BITS-1:0] width_q;
    logic [TO_W-1:0]       to_q;
    logic [RC_W-1:0]       rec_q;
    logic [WIDTH_BITS-1:0] pulse_q;
    logic [7:0]            thr_q;
    logic                  valid_q;
    logic                  fs_q;

    logic rise, fall, in_range, accept, reject, to_hit, release_now, fs_d;

    tick_1us #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock_i (clock),
        .reset_i (reset),
        .tick_o  (tick)
    );

    assign rise        = sync2_q & ~prev_q;
    assign fall        = ~sync2_q & prev_q;
    assign in_range    = (width_q >= MIN_W) && (width_q <= MAX_W);
    assign accept      = (state_q == ST_MEASURE) && fall && in_range;
    assign reject      = (state_q == ST_MEASURE) && fall && !in_range;
    assign to_hit      = tick && (to_q == TO_LAST) && !accept;
    assign release_now = fs_q && accept && (rec_q == RC_LAST);

    always_comb begin
        fs_d = fs_q;
        if (accept) begin
            fs_d = fs_q && !release_now;
        end else if (to_hit) begin
            fs_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            sync_vld_q <= 2'b00;
            state_q    <= ST_WAIT_LOW;
            width_q    <= '0;
            to_q       <= '0;
            rec_q      <= '0;
            pulse_q    <= '0;
            thr_q      <= '0;
            valid_q    <= 1'b0;
            fs_q       <= 1'b1;
        end else begin
            sync1_q    <= rc_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};

            fs_q    <= fs_d;
            valid_q <= accept && !fs_d;

            if (accept) begin
                pulse_q <= width_q;
                thr_q   <= fs_d ? 8'd0 : scale_throttle(width_q);
            end else if (to_hit) begin
                thr_q <= 8'd0;
            end

            if (accept) begin
                to_q <= '0;
            end else if (tick && (to_q != TO_MAX)) begin
                to_q <= to_q + 1'b1;
            end

            if (accept) begin
                rec_q <= (fs_q && !release_now) ? rec_q + 1'b1 : '0;
            end else if (reject || to_hit) begin
                rec_q <= '0;
            end

            case (state_q)
                // The reset value of the synchronizer is not a real sample; only
                // a low seen after it has filled may arm the capture.
                ST_WAIT_LOW: begin
                    if (sync_vld_q[1] && !sync2_q) begin
                        state_q <= ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    if (rise) begin
                        width_q <= tick ? WIDTH_BITS'(1) : '0;
                        state_q <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (fall) begin
                        state_q <= ST_WAIT_RISE;
                    end else if (tick && (width_q != WIDTH_SAT)) begin
                        width_q <= width_q + 1'b1;
                    end
                end
                default: state_q <= ST_WAIT_LOW;
            endcase
        end
    end

    assign pulse_us         = pulse_q;
    assign throttle_setting = thr_q;
    assign valid            = valid_q;
    assign failsafe         = fs_q;

endmodule
